// File: rtl/div_seq.sv
// Multi-cycle RV32M divider: radix-2 restoring divide, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module div_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic [1:0]      r_op;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special_quo;
    logic [XLEN-1:0] w_special_rem;
    logic [XLEN+1:0] w_trial;
    logic            w_trial_neg;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    // op[0]=1 selects the unsigned variants (DIVU/REMU)
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[XLEN-1];
    assign w_b_neg  = w_signed & b[XLEN-1];
    assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

    assign w_div0 = (b == '0);
    assign w_ovf  = w_signed && (a == MIN_NEG) && (b == '1);

    assign w_special_quo = w_div0 ? '1 : MIN_NEG;
    assign w_special_rem = w_div0 ? a  : '0;

    // Trial subtract on the shifted partial remainder, two guard bits keep the sign
    assign w_trial     = {1'b0, r_rem, r_quo[XLEN-1]} - {2'b00, r_div};
    assign w_trial_neg = w_trial[XLEN+1];

    assign w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_op    <= op;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_div   <= w_b_mag;
                        r_cnt   <= '0;
                        if (w_div0 || w_ovf) begin
                            r_quo    <= w_special_quo;
                            r_rem    <= w_special_rem;
                            r_result <= op[1] ? w_special_rem : w_special_quo;
                            r_state  <= S_DONE;
                        end else begin
                            r_quo   <= w_a_mag;
                            r_rem   <= '0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_quo <= {r_quo[XLEN-2:0], ~w_trial_neg};
                        r_rem <= w_trial_neg ? {r_rem[XLEN-2:0], r_quo[XLEN-1]}
                                             : w_trial[XLEN-1:0];
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(XLEN-1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_quo    <= w_quo_fix;
                        r_rem    <= w_rem_fix;
                        r_result <= r_op[1] ? w_rem_fix : w_quo_fix;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_div_seq.sv
// Randomized bench for div_seq: a cycle-level behavioural model checked every cycle,
// plus literal expectations for the reference vectors.
module tb_div_seq;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_err    = 0;

    div_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx;
        longint sy;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == MIN_NEG && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : MIN_NEG;
        if (o[0]) return o[1] ? (x % y) : (x / y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x,
                                       input logic [31:0] y);
        if (y == 32'd0) return 1;
        if (!o[0] && x == MIN_NEG && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Model: m_left counts cycles until the done cycle (1 = done cycle, 0 = idle)
    int          m_left;
    logic [31:0] m_result;
    logic [31:0] m_pending;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left    <= 0;
            m_result  <= 32'd0;
            m_pending <= 32'd0;
        end else if (m_left == 0) begin
            if (start && !flush) begin
                m_left    <= ref_latency(op, a, b);
                m_pending <= ref_result(op, a, b);
                if (ref_latency(op, a, b) == 1) m_result <= ref_result(op, a, b);
            end
        end else if (flush) begin
            m_left <= 0;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_result <= m_pending;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, m_left != 0});
        check("done", {31'd0, done}, {31'd0, m_left == 1});
        check("result", result, m_result);
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input int exp_lat, input string nm);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, " done_seen"}, {31'd0, done}, 32'd1);
        check({nm, " result"}, result, exp_res);
        check({nm, " latency"}, 32'(cyc), 32'(exp_lat));
        $display("txn %s op=%0d a=%h b=%h result=%h latency=%0d", nm, o, x, y, result, cyc);
    endtask

    logic [1:0]  r_o;
    logic [31:0] r_x;
    logic [31:0] r_y;
    int          sel;
    int          n_done;

    initial begin
        rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        #2 rst = 1'b1;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(2'b01, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, "rem_7_m2");
        run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_5_0");
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 1, "remu_5_0");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "rem_m5_0");
        run_op(2'b00, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1, "div_ovf");
        run_op(2'b10, MIN_NEG, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

        // Second start during RUN must be ignored
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        sel = 11;
        while (!done && sel < 100) begin
            @(negedge clk);
            sel++;
        end
        check("ignored_start result", result, 32'd14);
        check("ignored_start latency", 32'(sel), 32'd34);
        $display("txn ignored_start result=%h latency=%0d", result, sel);

        // Flush mid-RUN: back to IDLE, no done, result keeps previous value
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'h0000_FFFF; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush result", result, 32'd14);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("flush no_done", 32'(n_done), 32'd0);
        $display("txn flush_run result=%h", result);

        // Flush in IDLE beats start
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush busy", {31'd0, busy}, 32'd0);
        $display("txn idle_flush busy=%0d", busy);

        run_op(2'b01, 32'd9, 32'd3, 32'd3, 34, "divu_9_3");

        // Asynchronous reset between edges
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async busy", {31'd0, busy}, 32'd0);
        check("async done", {31'd0, done}, 32'd0);
        check("async result", result, 32'd0);
        $display("txn async_reset busy=%0d result=%h", busy, result);
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "divu_max_1");

        for (int i = 0; i < 40; i++) begin
            r_o = 2'($urandom_range(0, 3));
            r_x = $urandom;
            r_y = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                r_y = 32'd0;
            end else if (sel == 1) begin
                r_x = MIN_NEG; r_y = 32'hFFFF_FFFF; r_o[0] = 1'b0;
            end else if (sel == 2) begin
                r_y = 32'($urandom_range(1, 255));
            end else if (sel == 3) begin
                r_x = 32'($urandom_range(0, 1000));
            end
            run_op(r_o, r_x, r_y, ref_result(r_o, r_x, r_y), ref_latency(r_o, r_x, r_y), "rand");
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
